// File: rtl/ram_req_port_if.sv
// rtl/ram_req_port_if.sv - request/response bus between an initiator and ram_req_port
//
// Purpose: bundles the request (valid/ready/we/addr/wdata) and read-response
// (valid/ready/rdata) handshakes of the word-store port.
// Parameters: N address width, M data width.
// Modports:
//   master - initiator: drives req_valid, req_we, req_addr, req_wdata, rsp_ready
//   slave  - storage:   drives req_ready, rsp_valid, rsp_rdata
interface ram_req_port_if #(
  parameter int N = 6,
  parameter int M = 16
);
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [N-1:0] req_addr;
  logic [M-1:0] req_wdata;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [M-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/ram_req_port.sv
// rtl/ram_req_port.sv - single-port 2^N x M word store with clearing sweep and registered read response
//
// Purpose: services word read/write requests over a valid/ready handshake.
// After reset or a clr pulse the whole store is swept to zero (one word per
// cycle) before requests are accepted. Reads return through a registered,
// back-pressurable response channel.
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   clr       synchronous one-cycle pulse restarting the clearing sweep
//   init_done high once the clearing sweep has completed
//   bus       ram_req_port_if.slave (request and response handshakes)
module ram_req_port #(
  parameter int N = 6,
  parameter int M = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  output logic           init_done,
  ram_req_port_if.slave  bus
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic [M-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [M-1:0] mem_q [2**N];

  logic         req_ready;
  logic         acc_wr;
  logic         acc_rd;
  logic         sweep_last;
  logic         mem_we;
  logic [N-1:0] mem_waddr;
  logic [M-1:0] mem_wdata;

  // State register and sweep counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; clr wins over sweep progress in either state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sweep_last = (cnt_q == {N{1'b1}});
    if (clr) begin
      state_d = ST_INIT;
      cnt_d   = '0;
    end else if (state_q == ST_INIT) begin
      if (sweep_last) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Output / datapath control
  always_comb begin
    init_done = (state_q == ST_RUN);
    // A stalled response blocks every request, writes included, so the
    // initiator sees one uniform ready condition.
    req_ready = (state_q == ST_RUN) && !clr && (!rsp_valid_q || bus.rsp_ready);
    acc_wr    = req_ready && bus.req_valid && bus.req_we;
    acc_rd    = req_ready && bus.req_valid && !bus.req_we;
    mem_we    = 1'b0;
    mem_waddr = cnt_q;
    mem_wdata = '0;
    if (state_q == ST_INIT) begin
      mem_we = 1'b1;
    end else if (acc_wr) begin
      mem_we    = 1'b1;
      mem_waddr = bus.req_addr;
      mem_wdata = bus.req_wdata;
    end
  end

  assign bus.req_ready = req_ready;

  // Response register: a new read replaces a response being consumed in the
  // same cycle; clr leaves a pending response untouched.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    if (acc_rd) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = mem_q[bus.req_addr];
    end else if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  // Word store; no reset, contents are defined by the INIT sweep
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_ram_req_port.sv
// tb/tb_ram_req_port.sv - self-checking bench for ram_req_port
module tb_ram_req_port;
  localparam int N     = 6;
  localparam int M     = 16;
  localparam int DEPTH = 2**N;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clr   = 1'b0;
  logic init_done;

  ram_req_port_if #(.N(N), .M(M)) bus ();

  ram_req_port #(.N(N), .M(M)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .init_done (init_done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: remaining INIT cycles, word array, pending response
  int          m_init_left = DEPTH;
  logic [M-1:0] m_mem [DEPTH];
  bit          m_rsp_valid = 1'b0;
  logic [M-1:0] m_rsp_data = '0;
  bit          m_acc;

  function automatic bit m_ready();
    return (m_init_left == 0) && !clr && (!m_rsp_valid || bus.rsp_ready);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_init_left = DEPTH;
      m_rsp_valid = 1'b0;
      m_rsp_data  = '0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end else begin
      m_acc = m_ready() && bus.req_valid;
      if (m_rsp_valid && bus.rsp_ready) m_rsp_valid = 1'b0;
      if (m_acc && !bus.req_we) begin
        m_rsp_valid = 1'b1;
        m_rsp_data  = m_mem[bus.req_addr];
      end
      if (m_acc && bus.req_we) m_mem[bus.req_addr] = bus.req_wdata;
      if (clr) begin
        m_init_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      end else if (m_init_left > 0) begin
        m_init_left--;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("cyc_init_done", {31'b0, init_done}, {31'b0, m_init_left == 0});
    chk("cyc_req_ready", {31'b0, bus.req_ready}, {31'b0, m_ready()});
    chk("cyc_rsp_valid", {31'b0, bus.rsp_valid}, {31'b0, m_rsp_valid});
    if (m_rsp_valid) chk("cyc_rsp_rdata", {16'b0, bus.rsp_rdata}, {16'b0, m_rsp_data});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit we, input int addr, input logic [M-1:0] wd);
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = addr[N-1:0];
    bus.req_wdata = wd;
  endtask

  task automatic wait_init(input string name);
    int n;
    n = 0;
    while (!init_done && n < 200) begin
      tick();
      n++;
    end
    chk(name, n, DEPTH);
  endtask

  task automatic read_chk(input string name, input int addr, input logic [M-1:0] exp);
    drive(1'b1, 1'b0, addr, '0);
    tick();
    chk({name, "_valid"}, {31'b0, bus.rsp_valid}, 32'd1);
    chk({name, "_data"}, {16'b0, bus.rsp_rdata}, {16'b0, exp});
    drive(1'b0, 1'b0, 0, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 1'b0, 0, '0);
    bus.rsp_ready = 1'b1;
    #1;
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", {16'b0, bus.rsp_rdata}, 32'd0);
    chk("rst_init_done", {31'b0, init_done}, 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;

    // INIT length, request held during INIT must not be taken
    drive(1'b1, 1'b0, 0, '0);
    #1;
    chk("init_req_ready", {31'b0, bus.req_ready}, 32'd0);
    wait_init("init_len");
    drive(1'b0, 1'b0, 0, '0);

    // Back-to-back writes mem[i] = i+1, no response for writes
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, i, M'(i + 1));
      tick();
      chk("wr_no_rsp", {31'b0, bus.rsp_valid}, 32'd0);
    end
    // Back-to-back reads, each response one cycle after acceptance
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, i, '0);
      tick();
      chk("rd_valid", {31'b0, bus.rsp_valid}, 32'd1);
      chk("rd_data", {16'b0, bus.rsp_rdata}, 32'(i + 1));
    end
    drive(1'b0, 1'b0, 0, '0);
    tick();
    chk("rd_drain", {31'b0, bus.rsp_valid}, 32'd0);

    // Clear, then contents must read zero
    clr = 1'b1;
    tick();
    clr = 1'b0;
    wait_init("clr_len");
    read_chk("clr_rd0", 0, 16'h0000);
    read_chk("clr_rd9", 9, 16'h0000);
    read_chk("clr_rd63", 63, 16'h0000);
    tick();

    // Backpressure
    drive(1'b1, 1'b1, 7, 16'hBEEF);
    tick();
    drive(1'b1, 1'b1, 1, 16'h0111);
    tick();
    bus.rsp_ready = 1'b0;
    drive(1'b1, 1'b0, 7, '0);
    tick();
    drive(1'b1, 1'b0, 2, '0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'b0, bus.rsp_valid}, 32'd1);
      chk("bp_data", {16'b0, bus.rsp_rdata}, 32'hBEEF);
      chk("bp_req_ready", {31'b0, bus.req_ready}, 32'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    drive(1'b1, 1'b0, 1, '0);
    #1;
    chk("bp_release_ready", {31'b0, bus.req_ready}, 32'd1);
    tick();
    chk("bp_next_valid", {31'b0, bus.rsp_valid}, 32'd1);
    chk("bp_next_data", {16'b0, bus.rsp_rdata}, 32'h0111);
    drive(1'b0, 1'b0, 0, '0);
    tick();

    // Read-after-write, then reset with a response pending
    drive(1'b1, 1'b1, 5, 16'h1234);
    tick();
    bus.rsp_ready = 1'b0;
    read_chk("raw", 5, 16'h1234);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("arst_rsp_rdata", {16'b0, bus.rsp_rdata}, 32'd0);
    chk("arst_init_done", {31'b0, init_done}, 32'd0);
    bus.rsp_ready = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    wait_init("reinit_len");

    // clr together with a write: write must be refused
    clr = 1'b1;
    drive(1'b1, 1'b1, 3, 16'hFFFF);
    #1;
    chk("clr_req_ready", {31'b0, bus.req_ready}, 32'd0);
    tick();
    clr = 1'b0;
    drive(1'b0, 1'b0, 0, '0);
    wait_init("clr2_len");
    read_chk("clr_wr_rd3", 3, 16'h0000);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
